// File: rtl/fpga_display_ctrl_pkg.sv
// Shared types and constants for the FPGA board front end of the MIPS pipeline:
// debounce FSM encoding and the active-low hex-to-segment table.
package fpga_display_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } db_state_e;

  // Entry n holds the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/fpga_display_ctrl_hex_to_seg.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module hex_to_seg
  import fpga_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/fpga_display_ctrl.sv
// Board front end: debounced step strobe, debug register select, and a
// 4-digit multiplexed hex display of register data or PC.
module fpga_display_ctrl
  import fpga_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SCAN_CYCLES     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic [4:0]  sw_reg,
  input  logic        sw_mode,
  input  logic        sw_half,
  input  logic [31:0] read_reg_data,
  input  logic [31:0] read_pc,
  output logic [4:0]  read_reg,
  output logic        step_pulse,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

  logic             btn_s1, btn_s2;
  db_state_e        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             pulse_next;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        digit;
  logic [31:0]       val;
  logic [15:0]       half;
  logic [3:0]        nibble;
  logic [6:0]        seg_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_step;
      btn_s2 <= btn_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      step_pulse <= pulse_next;
    end
  end

  // The strobe fires only on the PRESS_CHK -> HELD transition, so a long hold
  // or a release never produces a second step.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s2) begin
          cnt_next   = '0;
          state_next = PRESS_CHK;
        end
      end
      PRESS_CHK: begin
        if (!btn_s2) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s2) begin
          cnt_next   = '0;
          state_next = REL_CHK;
        end
      end
      REL_CHK: begin
        if (btn_s2) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Live value: switches and pipeline data are sampled every cycle.
  assign val    = sw_mode ? read_pc : read_reg_data;
  assign half   = sw_half ? val[31:16] : val[15:0];
  assign nibble = half[{digit, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (seg_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      read_reg <= 5'd0;
      seg_n    <= 7'h7F;
      dp_n     <= 1'b1;
      an_n     <= 4'hF;
    end else begin
      read_reg <= sw_reg;
      seg_n    <= seg_next;
      dp_n     <= ~((digit == 2'd3) && sw_half);
      an_n     <= ~(4'b0001 << digit);
    end
  end

endmodule

// File: tb/tb_fpga_display_ctrl.sv
// Scoreboard bench for fpga_display_ctrl with short debounce and scan periods.
module tb_fpga_display_ctrl;

  localparam int DB = 4;
  localparam int SC = 2;

  localparam logic [6:0] HEXP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_step = 1'b0;
  logic [4:0]  sw_reg = 5'd0;
  logic        sw_mode = 1'b0;
  logic        sw_half = 1'b0;
  logic [31:0] read_reg_data = 32'd0;
  logic [31:0] read_pc = 32'd0;
  logic [4:0]  read_reg;
  logic        step_pulse;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int vectors = 0;
  int miscompares = 0;
  int cyc_no = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [4:0] rr;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];

  // Reference scan position: digit shown on the next edge.
  int         mcnt = 0;
  logic [1:0] md = 2'd0;

  always #5 clk = ~clk;

  fpga_display_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .SCAN_CYCLES     (SC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_step      (btn_step),
    .sw_reg        (sw_reg),
    .sw_mode       (sw_mode),
    .sw_half       (sw_half),
    .read_reg_data (read_reg_data),
    .read_pc       (read_pc),
    .read_reg      (read_reg),
    .step_pulse    (step_pulse),
    .seg_n         (seg_n),
    .dp_n          (dp_n),
    .an_n          (an_n)
  );

  always @(posedge clk) begin
    if (rst) begin
      mcnt <= 0;
      md   <= 2'd0;
    end else if (mcnt == SC - 1) begin
      mcnt <= 0;
      md   <= md + 2'd1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  function automatic exp_t predict();
    exp_t        e;
    logic [31:0] v;
    logic [15:0] h;
    logic [3:0]  nib;
    if (rst) begin
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      e.rr  = 5'd0;
    end else begin
      v = sw_mode ? read_pc : read_reg_data;
      h = sw_half ? v[31:16] : v[15:0];
      case (md)
        2'd0: begin nib = h[3:0];   e.an = 4'hE; end
        2'd1: begin nib = h[7:4];   e.an = 4'hD; end
        2'd2: begin nib = h[11:8];  e.an = 4'hB; end
        default: begin nib = h[15:12]; e.an = 4'h7; end
      endcase
      e.seg = HEXP[nib];
      e.dp  = (md == 2'd3 && sw_half) ? 1'b0 : 1'b1;
      e.rr  = sw_reg;
    end
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    exp_q.push_back(predict());
    @(posedge clk);
    #1;
    cyc_no++;
    e = exp_q.pop_front();
    vectors++;
    if (an_n !== e.an) begin
      miscompares++;
      $display("FAIL an_n cycle %0d: got %h want %h", cyc_no, an_n, e.an);
    end
    vectors++;
    if (seg_n !== e.seg) begin
      miscompares++;
      $display("FAIL seg_n cycle %0d: got %h want %h", cyc_no, seg_n, e.seg);
    end
    vectors++;
    if (dp_n !== e.dp) begin
      miscompares++;
      $display("FAIL dp_n cycle %0d: got %b want %b", cyc_no, dp_n, e.dp);
    end
    vectors++;
    if (read_reg !== e.rr) begin
      miscompares++;
      $display("FAIL read_reg cycle %0d: got %0d want %0d", cyc_no, read_reg, e.rr);
    end
    vectors++;
    if (pulse_q.size() > 0 && pulse_q[0] == cyc_no) begin
      void'(pulse_q.pop_front());
      if (step_pulse !== 1'b1) begin
        miscompares++;
        $display("FAIL step_pulse cycle %0d: got %b want 1", cyc_no, step_pulse);
      end
    end else if (step_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL step_pulse cycle %0d: got %b want 0", cyc_no, step_pulse);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // The first edge that samples a new 1 is cyc_no+1; the strobe follows 6 edges later.
  task automatic expect_pulse();
    pulse_q.push_back(cyc_no + 7);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (pulse_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s pending strobes: got %0d outstanding want 0", name, pulse_q.size());
      pulse_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2);
  endtask

  task automatic test_step();
    btn_step = 1'b1;
    expect_pulse();
    run(40);
    btn_step = 1'b0;
    run(2);
    btn_step = 1'b1;
    run(10);
    btn_step = 1'b0;
    run(12);
    check_drained("step");
  endtask

  task automatic test_bounce();
    repeat (2) begin
      btn_step = 1'b1;
      run(2);
      btn_step = 1'b0;
      run(2);
    end
    run(8);
    btn_step = 1'b1;
    expect_pulse();
    run(12);
    btn_step = 1'b0;
    run(10);
    check_drained("bounce");
  endtask

  task automatic test_display();
    sw_mode = 1'b0;
    sw_half = 1'b0;
    read_reg_data = 32'h1234ABCD;
    run(8);
    run(3);
    sw_half = 1'b1;
    run(9);
  endtask

  task automatic test_pc();
    sw_mode = 1'b1;
    sw_half = 1'b1;
    read_pc = 32'h00400010;
    run(8);
    read_pc = 32'hFEDC9876;
    run(4);
    sw_half = 1'b0;
    run(8);
  endtask

  task automatic test_reg_and_reset();
    sw_reg = 5'd17;
    run(2);
    sw_reg = 5'd31;
    run(1);
    btn_step = 1'b1;
    expect_pulse();
    run(10);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    expect_pulse();
    run(12);
    btn_step = 1'b0;
    run(10);
    check_drained("reset_mid_press");
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_display();
    test_pc();
    test_reg_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
